// File: rtl/mc_cu_pkg.sv
// Shared definitions for the multi-cycle control unit: state codes, opcode/func
// constants, ALU/mux encodings and the decoded-instruction flag bundle.
package mc_cu_pkg;

    typedef enum logic [2:0] {
        StIf  = 3'd0,
        StId  = 3'd1,
        StExe = 3'd2,
        StMem = 3'd3,
        StWb  = 3'd4
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpXori  = 6'b001110;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnXor = 6'b100110;
    localparam logic [5:0] FnSll = 6'b000000;
    localparam logic [5:0] FnSrl = 6'b000010;
    localparam logic [5:0] FnSra = 6'b000011;
    localparam logic [5:0] FnJr  = 6'b001000;

    localparam logic [3:0] AlucAdd = 4'b0000;
    localparam logic [3:0] AlucSub = 4'b0100;
    localparam logic [3:0] AlucAnd = 4'b0001;
    localparam logic [3:0] AlucOr  = 4'b0101;
    localparam logic [3:0] AlucXor = 4'b0010;
    localparam logic [3:0] AlucLui = 4'b0110;
    localparam logic [3:0] AlucSll = 4'b0011;
    localparam logic [3:0] AlucSrl = 4'b0111;
    localparam logic [3:0] AlucSra = 4'b1111;

    localparam logic [1:0] SrcbReg  = 2'b00;
    localparam logic [1:0] SrcbFour = 2'b01;
    localparam logic [1:0] SrcbImm  = 2'b10;
    localparam logic [1:0] SrcbBr   = 2'b11;

    localparam logic [1:0] PcAlu    = 2'b00;
    localparam logic [1:0] PcAluOut = 2'b01;
    localparam logic [1:0] PcRs     = 2'b10;
    localparam logic [1:0] PcJump   = 2'b11;

    typedef struct packed {
        logic i_add;
        logic i_sub;
        logic i_and;
        logic i_or;
        logic i_xor;
        logic i_sll;
        logic i_srl;
        logic i_sra;
        logic i_jr;
        logic i_addi;
        logic i_andi;
        logic i_ori;
        logic i_xori;
        logic i_lui;
        logic i_lw;
        logic i_sw;
        logic i_beq;
        logic i_bne;
        logic i_j;
        logic i_jal;
    } inst_t;

    function automatic logic [3:0] inst_aluc(inst_t i);
        logic [3:0] a;
        a = AlucAdd;
        if (i.i_sub | i.i_beq | i.i_bne) a = AlucSub;
        if (i.i_and | i.i_andi)          a = AlucAnd;
        if (i.i_or  | i.i_ori)           a = AlucOr;
        if (i.i_xor | i.i_xori)          a = AlucXor;
        if (i.i_lui)                     a = AlucLui;
        if (i.i_sll)                     a = AlucSll;
        if (i.i_srl)                     a = AlucSrl;
        if (i.i_sra)                     a = AlucSra;
        return a;
    endfunction

endpackage

// File: rtl/mc_cu_decode.sv
// Combinational instruction decoder: op/func to one-hot instruction flags,
// with illegal raised when nothing in the supported subset matches.
module mc_cu_decode
    import mc_cu_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output inst_t      inst,
    output logic       illegal
);

    always_comb begin
        inst = '0;
        unique case (op)
            OpRtype: begin
                unique case (func)
                    FnAdd:   inst.i_add = 1'b1;
                    FnSub:   inst.i_sub = 1'b1;
                    FnAnd:   inst.i_and = 1'b1;
                    FnOr:    inst.i_or  = 1'b1;
                    FnXor:   inst.i_xor = 1'b1;
                    FnSll:   inst.i_sll = 1'b1;
                    FnSrl:   inst.i_srl = 1'b1;
                    FnSra:   inst.i_sra = 1'b1;
                    FnJr:    inst.i_jr  = 1'b1;
                    default: ;
                endcase
            end
            OpAddi:  inst.i_addi = 1'b1;
            OpAndi:  inst.i_andi = 1'b1;
            OpOri:   inst.i_ori  = 1'b1;
            OpXori:  inst.i_xori = 1'b1;
            OpLui:   inst.i_lui  = 1'b1;
            OpLw:    inst.i_lw   = 1'b1;
            OpSw:    inst.i_sw   = 1'b1;
            OpBeq:   inst.i_beq  = 1'b1;
            OpBne:   inst.i_bne  = 1'b1;
            OpJ:     inst.i_j    = 1'b1;
            OpJal:   inst.i_jal  = 1'b1;
            default: ;
        endcase
        illegal = ~|inst;
    end

endmodule

// File: rtl/mc_cu.sv
// Multi-cycle control unit: IF/ID/EXE/MEM/WB sequencer with per-state enables/selects.
// Optional memory wait states are enabled with `define MC_CU_MEMWAIT_EN.
module mc_cu
    import mc_cu_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       z,
`ifdef MC_CU_MEMWAIT_EN
    input  logic       mem_ready,
`endif
    output logic       wpc,
    output logic       wir,
    output logic       wmem,
    output logic       wreg,
    output logic       iord,
    output logic       regrt,
    output logic       m2reg,
    output logic       jal,
    output logic       sext,
    output logic       shift,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [3:0] aluc,
    output logic [1:0] pcsource,
    output logic [2:0] state
);

    state_e state_q, state_d;
    inst_t  inst;
    logic   illegal;
    logic   ready;
    logic   is_imm;
    logic   is_itype;
    logic   is_branch;
    logic   br_taken;

`ifdef MC_CU_MEMWAIT_EN
    assign ready = mem_ready;
`else
    assign ready = 1'b1;
`endif

    mc_cu_decode u_decode (
        .op      (op),
        .func    (func),
        .inst    (inst),
        .illegal (illegal)
    );

    assign is_itype  = inst.i_addi | inst.i_andi | inst.i_ori | inst.i_xori |
                       inst.i_lui | inst.i_lw;
    assign is_imm    = is_itype | inst.i_sw;
    assign is_branch = inst.i_beq | inst.i_bne;
    assign br_taken  = (inst.i_beq & z) | (inst.i_bne & ~z);

    always_comb begin
        state_d  = StIf;
        wpc      = 1'b0;
        wir      = 1'b0;
        wmem     = 1'b0;
        wreg     = 1'b0;
        iord     = 1'b0;
        regrt    = 1'b0;
        m2reg    = 1'b0;
        jal      = 1'b0;
        sext     = 1'b0;
        shift    = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = SrcbReg;
        aluc     = AlucAdd;
        pcsource = PcAlu;
        state    = 3'd0;
        // Reset leaves every output at its zero default and steers back to IF.
        if (resetn) begin
            state = state_q;
            unique case (state_q)
                StIf: begin
                    alusrcb = SrcbFour;
                    wpc     = ready;
                    wir     = ready;
                    state_d = ready ? StId : StIf;
                end
                StId: begin
                    alusrcb = SrcbBr;
                    if (inst.i_j || inst.i_jal) begin
                        pcsource = PcJump;
                        wpc      = 1'b1;
                    end
                    if (inst.i_jal) begin
                        wreg = 1'b1;
                        jal  = 1'b1;
                    end
                    if (inst.i_jr) begin
                        pcsource = PcRs;
                        wpc      = 1'b1;
                    end
                    state_d = (inst.i_j || inst.i_jal || inst.i_jr || illegal) ? StIf : StExe;
                end
                StExe: begin
                    alusrca = 1'b1;
                    shift   = inst.i_sll | inst.i_srl | inst.i_sra;
                    alusrcb = is_imm ? SrcbImm : SrcbReg;
                    aluc    = inst_aluc(inst);
                    sext    = inst.i_addi | inst.i_lw | inst.i_sw | is_branch;
                    if (br_taken) begin
                        pcsource = PcAluOut;
                        wpc      = 1'b1;
                    end
                    if (is_branch)                   state_d = StIf;
                    else if (inst.i_lw || inst.i_sw) state_d = StMem;
                    else                             state_d = StWb;
                end
                StMem: begin
                    iord = 1'b1;
                    wmem = inst.i_sw;
                    if (!ready)         state_d = StMem;
                    else if (inst.i_lw) state_d = StWb;
                    else                state_d = StIf;
                end
                StWb: begin
                    wreg  = 1'b1;
                    regrt = is_itype;
                    m2reg = inst.i_lw;
                end
                default: begin
                    // Illegal encodings: all enables stay low, recover to IF.
                    state = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) state_q <= StIf;
        else         state_q <= state_d;
    end

endmodule

// File: tb/tb_mc_cu.sv
// Self-checking bench for mc_cu: directed cases then randomized instructions,
// each cycle checked against a per-instruction sequence model.
module tb_mc_cu;

    logic       clock = 1'b0;
    logic       resetn;
    logic [5:0] op, func;
    logic       z;
`ifdef MC_CU_MEMWAIT_EN
    logic       mem_ready;
`endif
    logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift, alusrca;
    logic [1:0] alusrcb, pcsource;
    logic [3:0] aluc;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mc_cu dut (
        .clock    (clock),
        .resetn   (resetn),
        .op       (op),
        .func     (func),
        .z        (z),
`ifdef MC_CU_MEMWAIT_EN
        .mem_ready(mem_ready),
`endif
        .wpc      (wpc),
        .wir      (wir),
        .wmem     (wmem),
        .wreg     (wreg),
        .iord     (iord),
        .regrt    (regrt),
        .m2reg    (m2reg),
        .jal      (jal),
        .sext     (sext),
        .shift    (shift),
        .alusrca  (alusrca),
        .alusrcb  (alusrcb),
        .aluc     (aluc),
        .pcsource (pcsource),
        .state    (state)
    );

    typedef struct packed {
        logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift, alusrca;
        logic [1:0] alusrcb;
        logic [3:0] aluc;
        logic [1:0] pcsource;
        logic [2:0] state;
    } outs_t;

    outs_t obs;
    assign obs = {wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift, alusrca,
                  alusrcb, aluc, pcsource, state};

    localparam int CAlu = 0, CLw = 1, CSw = 2, CBeq = 3, CBne = 4, CJ = 5, CJal = 6,
                   CJr = 7, CIll = 8;

    typedef struct {
        logic [5:0] op;
        logic [5:0] func;
        logic [3:0] aluc;
        bit         imm;
        bit         wrt;
        bit         sx;
        bit         sh;
        int         cls;
    } ins_t;

    ins_t tab [22];

    initial begin
        tab[0]  = '{6'b000000, 6'b100000, 4'b0000, 0, 0, 0, 0, CAlu}; // add
        tab[1]  = '{6'b000000, 6'b100010, 4'b0100, 0, 0, 0, 0, CAlu}; // sub
        tab[2]  = '{6'b000000, 6'b100100, 4'b0001, 0, 0, 0, 0, CAlu}; // and
        tab[3]  = '{6'b000000, 6'b100101, 4'b0101, 0, 0, 0, 0, CAlu}; // or
        tab[4]  = '{6'b000000, 6'b100110, 4'b0010, 0, 0, 0, 0, CAlu}; // xor
        tab[5]  = '{6'b000000, 6'b000000, 4'b0011, 0, 0, 0, 1, CAlu}; // sll
        tab[6]  = '{6'b000000, 6'b000010, 4'b0111, 0, 0, 0, 1, CAlu}; // srl
        tab[7]  = '{6'b000000, 6'b000011, 4'b1111, 0, 0, 0, 1, CAlu}; // sra
        tab[8]  = '{6'b000000, 6'b001000, 4'b0000, 0, 0, 0, 0, CJr};  // jr
        tab[9]  = '{6'b001000, 6'b000000, 4'b0000, 1, 1, 1, 0, CAlu}; // addi
        tab[10] = '{6'b001100, 6'b000000, 4'b0001, 1, 1, 0, 0, CAlu}; // andi
        tab[11] = '{6'b001101, 6'b000000, 4'b0101, 1, 1, 0, 0, CAlu}; // ori
        tab[12] = '{6'b001110, 6'b000000, 4'b0010, 1, 1, 0, 0, CAlu}; // xori
        tab[13] = '{6'b001111, 6'b000000, 4'b0110, 1, 1, 0, 0, CAlu}; // lui
        tab[14] = '{6'b100011, 6'b000000, 4'b0000, 1, 1, 1, 0, CLw};  // lw
        tab[15] = '{6'b101011, 6'b000000, 4'b0000, 1, 0, 1, 0, CSw};  // sw
        tab[16] = '{6'b000100, 6'b000000, 4'b0100, 0, 0, 1, 0, CBeq}; // beq
        tab[17] = '{6'b000101, 6'b000000, 4'b0100, 0, 0, 1, 0, CBne}; // bne
        tab[18] = '{6'b000010, 6'b000000, 4'b0000, 0, 0, 0, 0, CJ};   // j
        tab[19] = '{6'b000011, 6'b000000, 4'b0000, 0, 0, 0, 0, CJal}; // jal
        tab[20] = '{6'b010000, 6'b000000, 4'b0000, 0, 0, 0, 0, CIll}; // bad op
        tab[21] = '{6'b000000, 6'b111111, 4'b0000, 0, 0, 0, 0, CIll}; // bad func
    end

    function automatic outs_t expect_out(int k, int st, bit zz, bit rdy, bit rst);
        outs_t e;
        e = '0;
        if (rst) return e;
        e.state = 3'(st);
        case (st)
            0: begin
                e.alusrcb = 2'b01;
                e.wpc     = rdy;
                e.wir     = rdy;
            end
            1: begin
                e.alusrcb = 2'b11;
                if (tab[k].cls == CJ || tab[k].cls == CJal) begin
                    e.pcsource = 2'b11;
                    e.wpc      = 1'b1;
                end
                if (tab[k].cls == CJal) begin
                    e.wreg = 1'b1;
                    e.jal  = 1'b1;
                end
                if (tab[k].cls == CJr) begin
                    e.pcsource = 2'b10;
                    e.wpc      = 1'b1;
                end
            end
            2: begin
                e.alusrca = 1'b1;
                e.shift   = tab[k].sh;
                e.alusrcb = tab[k].imm ? 2'b10 : 2'b00;
                e.aluc    = tab[k].aluc;
                e.sext    = tab[k].sx;
                if ((tab[k].cls == CBeq && zz) || (tab[k].cls == CBne && !zz)) begin
                    e.pcsource = 2'b01;
                    e.wpc      = 1'b1;
                end
            end
            3: begin
                e.iord = 1'b1;
                e.wmem = (tab[k].cls == CSw);
            end
            4: begin
                e.wreg  = 1'b1;
                e.regrt = tab[k].wrt;
                e.m2reg = (tab[k].cls == CLw);
            end
            default: ;
        endcase
        return e;
    endfunction

    // Run one instruction: abort_at is the step index where reset is pulsed (-1: none),
    // zf forces z (-1: random), stall counts are not-ready cycles before IF / MEM complete.
    task automatic run(input int k, input int abort_at, input int sif_stall,
                       input int mem_stall, input int zf);
        int    seq[$];
        int    idx, st, sif_left, mem_left;
        bit    rdy, rst;
        outs_t e;
        case (tab[k].cls)
            CLw:                 seq = '{0, 1, 2, 3, 4};
            CSw:                 seq = '{0, 1, 2, 3};
            CBeq, CBne:          seq = '{0, 1, 2};
            CJ, CJal, CJr, CIll: seq = '{0, 1};
            default:             seq = '{0, 1, 2, 4};
        endcase
`ifdef MC_CU_MEMWAIT_EN
        sif_left = sif_stall;
        mem_left = mem_stall;
`else
        sif_left = 0 * sif_stall;
        mem_left = 0 * mem_stall;
`endif
        op   = tab[k].op;
        func = (tab[k].op == 6'b000000) ? tab[k].func : 6'($urandom);
        idx  = 0;
        while (idx < seq.size()) begin
            st  = seq[idx];
            rdy = 1'b1;
            if (st == 0 && sif_left > 0) begin
                rdy = 1'b0;
                sif_left--;
            end
            if (st == 3 && mem_left > 0) begin
                rdy = 1'b0;
                mem_left--;
            end
            rst    = (idx == abort_at);
            resetn = !rst;
            z      = (zf < 0) ? 1'($urandom) : 1'(zf);
`ifdef MC_CU_MEMWAIT_EN
            mem_ready = rdy;
`endif
            @(negedge clock);
            e = expect_out(k, st, z, rdy, rst);
            checks++;
            assert (obs === e) else begin
                errors++;
                $error("FAIL ins%0d step%0d obs=%h exp=%h", k, idx, obs, e);
            end
            @(posedge clock);
            #1;
            if (rst) break;
            if (rdy) idx++;
        end
    endtask

    initial begin
        resetn = 1'b0;
        op     = 6'b000000;
        func   = 6'b100000;
        z      = 1'b0;
`ifdef MC_CU_MEMWAIT_EN
        mem_ready = 1'b0;
`endif
        repeat (2) begin
            @(negedge clock);
            checks++;
            assert (obs === outs_t'(0)) else begin
                errors++;
                $error("FAIL reset obs=%h exp=%h", obs, outs_t'(0));
            end
        end
        @(posedge clock);
        #1;

        run(0, -1, 0, 0, -1);   // add
        run(14, -1, 0, 0, -1);  // lw
        run(16, -1, 0, 0, 1);   // beq taken
        run(16, -1, 0, 0, 0);   // beq not taken
        run(17, -1, 0, 0, 0);   // bne taken
        run(19, -1, 0, 0, -1);  // jal
        run(15, 3, 0, 0, -1);   // sw aborted in MEM
        run(0, -1, 0, 0, -1);   // restart from IF
        run(21, -1, 0, 0, -1);  // unsupported func
`ifdef MC_CU_MEMWAIT_EN
        run(0, -1, 3, 0, -1);
        run(15, -1, 1, 2, -1);
        run(14, 3, 0, 2, -1);
        run(14, 0, 2, 0, -1);
`endif

        for (int n = 0; n < 300; n++) begin
            int k, ab, s0, s1;
            k  = int'($urandom_range(0, 21));
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
            s0 = int'($urandom_range(0, 2));
            s1 = int'($urandom_range(0, 2));
            run(k, ab, s0, s1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
